switch_debounce: RTL and testbench

- Input-conditioning stage directly upstream of the MIPS core's 8-bit `switch` input port.
- Synchronises raw board switches into `clk`, debounces each bit independently and presents a clean `sw_db` bus for the core to read.
- Also emits per-bit edge pulses and an aggregate change strobe for memory-mapped I/O polling.

---
 rtl/sw_debounce_pkg.sv | 12 +
 rtl/debounce_bit.sv | 68 ++++++
 rtl/switch_debounce.sv | 76 +++++++
 tb/tb_switch_debounce.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared constants for the switch debounce stage: production defaults and a short
// stability window for simulation.
package sw_debounce_pkg;

  localparam int unsigned DEF_WIDTH         = 8;
  localparam int unsigned DEF_CNT_W         = 16;
  localparam int unsigned DEF_STABLE_CYCLES = 50000;

  // Short window so benches can see debounce events within a few cycles.
  localparam int unsigned SIM_STABLE_CYCLES = 4;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: two-flop synchroniser, mismatch-streak counter, debounced value
// and one-cycle rise/fall pulses.
module debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_db,
  output logic o_rise,
  output logic o_fall,
  output logic o_upd_c
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_db;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_upd;

  // Count consecutive cycles where the synchronised pin disagrees with the debounced value.
  always_comb begin
    w_cnt_nxt = '0;
    w_upd     = 1'b0;
    if (r_sync != r_db) begin
      if (r_cnt == LP_LAST) begin
        w_upd = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_cnt  <= '0;
      r_db   <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      r_cnt  <= w_cnt_nxt;
      if (w_upd) begin
        r_db <= r_sync;
      end
      r_rise <= w_upd & r_sync;
      r_fall <= w_upd & ~r_sync;
    end
  end

  assign o_db    = r_db;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;
  assign o_upd_c = w_upd;

endmodule

// File: rtl/switch_debounce.sv
// Debounced switch bus for the core's switch port, with edge pulses and a change strobe.
// Define SW_DEBOUNCE_LATCH_EN to enable the sticky chg_latched flags cleared by chg_ack.
module switch_debounce
  import sw_debounce_pkg::*;
#(
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_change,
  input  logic [WIDTH-1:0] chg_ack,
  output logic [WIDTH-1:0] chg_latched
);

  logic [WIDTH-1:0] w_db;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_upd;
  logic             r_change;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    debounce_bit #(
      .CNT_W         (CNT_W),
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_bit (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (sw_raw[gi]),
      .o_db    (w_db[gi]),
      .o_rise  (w_rise[gi]),
      .o_fall  (w_fall[gi]),
      .o_upd_c (w_upd[gi])
    );
  end

  // Registered from the per-bit update strobes so it lines up with the rise/fall pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_change <= 1'b0;
    end else begin
      r_change <= |w_upd;
    end
  end

`ifdef SW_DEBOUNCE_LATCH_EN
  logic [WIDTH-1:0] r_latched;

  // A new edge pulse takes priority over an ack arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_latched <= '0;
    end else begin
      r_latched <= (r_latched & ~chg_ack) | w_rise | w_fall;
    end
  end

  assign chg_latched = r_latched;
`else
  logic w_unused_ack;

  assign w_unused_ack = ^chg_ack;
  assign chg_latched  = '0;
`endif

  assign sw_db     = w_db;
  assign sw_rise   = w_rise;
  assign sw_fall   = w_fall;
  assign sw_change = r_change;

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce with the short simulation stability window.
module tb_switch_debounce;
  import sw_debounce_pkg::*;

  localparam int unsigned W = 8;

`ifdef SW_DEBOUNCE_LATCH_EN
  localparam logic [W-1:0] LAT_MASK = 8'hFF;
`else
  localparam logic [W-1:0] LAT_MASK = 8'h00;
`endif

  typedef struct {
    int           cyc;
    logic [W-1:0] db;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         chg;
    logic [W-1:0] lat;
    string        tag;
  } exp_t;

  logic         clk;
  logic         reset;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_db;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         sw_change;
  logic [W-1:0] chg_ack;
  logic [W-1:0] chg_latched;

  int   ec;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  switch_debounce #(
    .WIDTH         (W),
    .CNT_W         (16),
    .STABLE_CYCLES (SIM_STABLE_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sw_raw      (sw_raw),
    .sw_db       (sw_db),
    .sw_rise     (sw_rise),
    .sw_fall     (sw_fall),
    .sw_change   (sw_change),
    .chg_ack     (chg_ack),
    .chg_latched (chg_latched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial ec = 0;
  always @(posedge clk) ec <= ec + 1;

  function automatic logic [W-1:0] lx(input logic [W-1:0] v);
    return v & LAT_MASK;
  endfunction

  task automatic push(input int cyc, input logic [W-1:0] db, input logic [W-1:0] rise,
                      input logic [W-1:0] fall, input logic chg, input logic [W-1:0] lat,
                      input string tag);
    exp_t e;
    e.cyc = cyc; e.db = db; e.rise = rise; e.fall = fall;
    e.chg = chg; e.lat = lat; e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Returns #1 after posedge number n.
  task automatic at_edge(input int n);
    while (ec < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cmp(input string tag, input string fld, input int cyc,
                     input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s cycle %0d: got %h expected %h", tag, fld, cyc, act, exp);
    end
  endtask

  // Monitor: compares every expectation due at the current edge count.
  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc == ec) begin
        cmp(sb_q[i].tag, "sw_db",       ec, sw_db,          sb_q[i].db);
        cmp(sb_q[i].tag, "sw_rise",     ec, sw_rise,        sb_q[i].rise);
        cmp(sb_q[i].tag, "sw_fall",     ec, sw_fall,        sb_q[i].fall);
        cmp(sb_q[i].tag, "sw_change",   ec, W'(sw_change),  W'(sb_q[i].chg));
        cmp(sb_q[i].tag, "chg_latched", ec, chg_latched,    sb_q[i].lat);
        sb_q.delete(i);
      end else if (sb_q[i].cyc < ec) begin
        checks++;
        errors++;
        $display("FAIL %s stale: due cycle %0d, now %0d", sb_q[i].tag, sb_q[i].cyc, ec);
        sb_q.delete(i);
      end
    end
  end

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    sw_raw  = 8'hFA;
    chg_ack = 8'h00;

    // 1: power-up with switches high
    push(2, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, "reset");
    for (int c = 3; c <= 7; c++) push(c, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, "t1_wait");
    push(8, 8'hFA, 8'hFA, 8'h00, 1'b1, 8'h00, "t1_update");
    push(9, 8'hFA, 8'h00, 8'h00, 1'b0, lx(8'hFA), "t1_after");
    at_edge(2);  reset = 1'b0;
    at_edge(9);  chg_ack = 8'hFF;
    push(10, 8'hFA, 8'h00, 8'h00, 1'b0, 8'h00, "t1_ack");

    // 2: glitch of STABLE_CYCLES-1 on bit 0
    at_edge(10); chg_ack = 8'h00; sw_raw = 8'hFB;
    for (int c = 11; c <= 20; c++) push(c, 8'hFA, 8'h00, 8'h00, 1'b0, 8'h00, "t2_glitch");
    at_edge(13); sw_raw = 8'hFA;

    // 3: bit 7 falls
    at_edge(20); sw_raw = 8'h7A;
    push(25, 8'hFA, 8'h00, 8'h00, 1'b0, 8'h00, "t3_pre");
    push(26, 8'h7A, 8'h00, 8'h80, 1'b1, 8'h00, "t3_update");
    push(27, 8'h7A, 8'h00, 8'h00, 1'b0, lx(8'h80), "t3_after");
    at_edge(27); chg_ack = 8'h80;
    push(28, 8'h7A, 8'h00, 8'h00, 1'b0, 8'h00, "t3_ack");

    // 4: reset in the middle of a count
    at_edge(28); chg_ack = 8'h00; sw_raw = 8'hFA;
    push(32, 8'h7A, 8'h00, 8'h00, 1'b0, 8'h00, "t4_counting");
    at_edge(32); reset = 1'b1;
    push(33, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, "t4_reset");
    at_edge(33); reset = 1'b0;
    for (int c = 34; c <= 38; c++) push(c, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, "t4_wait");
    push(39, 8'hFA, 8'hFA, 8'h00, 1'b1, 8'h00, "t4_update");
    push(40, 8'hFA, 8'h00, 8'h00, 1'b0, lx(8'hFA), "t4_after");
    at_edge(40); chg_ack = 8'hFF;
    push(41, 8'hFA, 8'h00, 8'h00, 1'b0, 8'h00, "t4_ack");

    // 5/6: sticky flags on bit 1, including ack colliding with a new pulse
    at_edge(41); chg_ack = 8'h00; sw_raw = 8'hF8;
    push(46, 8'hFA, 8'h00, 8'h00, 1'b0, 8'h00, "t5_pre_fall");
    push(47, 8'hF8, 8'h00, 8'h02, 1'b1, 8'h00, "t5_fall");
    push(48, 8'hF8, 8'h00, 8'h00, 1'b0, lx(8'h02), "t5_latched");
    at_edge(48); chg_ack = 8'h02;
    push(49, 8'hF8, 8'h00, 8'h00, 1'b0, 8'h00, "t5_acked");
    at_edge(49); chg_ack = 8'h00; sw_raw = 8'hFA;
    push(54, 8'hF8, 8'h00, 8'h00, 1'b0, 8'h00, "t5_pre_rise");
    push(55, 8'hFA, 8'h02, 8'h00, 1'b1, 8'h00, "t5_rise");
    at_edge(55); chg_ack = 8'h02;
    push(56, 8'hFA, 8'h00, 8'h00, 1'b0, lx(8'h02), "t5_set_wins");
    at_edge(56); chg_ack = 8'h00;
    push(57, 8'hFA, 8'h00, 8'h00, 1'b0, lx(8'h02), "t5_hold");
    at_edge(57); chg_ack = 8'h02;
    push(58, 8'hFA, 8'h00, 8'h00, 1'b0, 8'h00, "t5_final_ack");
    at_edge(58); chg_ack = 8'h00;

    at_edge(62);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
